csr_timer_bank: RTL and testbench
=================================

CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 Parameter NUM_TIMERS, default 2, number of independent timer channels (legal 1..4).
REQ-002 Parameter TIMER_WIDTH, default 32, width of each TVAL/InitVal field (legal 4..32).
REQ-003 Parameter CNT_WIDTH, default 64, stable-counter width (legal 33..64).
REQ-004 Parameter CSR_STRIDE, default 14'h8, CSR-number spacing between channels.
REQ-005 Clock clk; reset reset, synchronous, active-high.
REQ-006 Ports, in order (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- csr_we, in, 1, CSR write strobe.
- csr_me, in, 1, masked-write enable (csrxchg).
- csr_wnum, in, 14, write CSR number.
- csr_wdata, in, 32, write data.
- csr_wmask, in, 32, write mask.
- csr_rnum, in, 14, read CSR number.
- csr_rdata, out, 32, combinational read data.
- timer_irq, out, NUM_TIMERS, per-channel pending interrupt.
- irq_any, out, 1, OR of timer_irq.
- counter_hi, out, 32, stable counter [CNT_WIDTH-1:32], zero-extended.
- counter_lo, out, 32, stable counter [31:0].

Function
REQ-007 Channel i CSR numbers: TCFG = TCFG_BASE + i*CSR_STRIDE, TVAL = TVAL_BASE + i*CSR_STRIDE, TICLR = TICLR_BASE + i*CSR_STRIDE.
REQ-008 Effective write value = (wdata & m) | (old & ~m), where m = csr_me ? csr_wmask : all-ones; state updates on the clk edge.
REQ-009 TCFG fields: [0] En, [1] Periodic, [TIMER_WIDTH-1:2] InitVal; bits above TIMER_WIDTH read 0.
REQ-010 A TCFG write loads TVAL = {InitVal,2'b00} on the same edge, regardless of En.
REQ-011 When En=1 and TVAL != 0, TVAL decrements by 1 per cycle.
REQ-012 Expiry is TVAL==1 while counting:
- set pending[i] next cycle;
- Periodic=1: reload {InitVal,2'b00};
- Periodic=0: TVAL becomes 0 and halts, with no wrap.
REQ-013 En=0 freezes TVAL. Periodic InitVal=0 reloads 0 and stops after the first expiry.
REQ-014 TVAL writes are ignored (read-only).
REQ-015 A TICLR write with effective bit0=1 clears pending[i] on that edge; TICLR reads return 0.
REQ-016 Simultaneous TICLR clear and expiry on the same channel: pending remains 1 (expiry wins).
REQ-017 Simultaneous TCFG write and expiry on the same channel: TVAL takes the TCFG-load value; pending is still set.
REQ-018 timer_irq[i] = pending[i] (registered); irq_any = |pending.
REQ-019 Stable counter increments by 1 every cycle and wraps modulo 2^CNT_WIDTH.
REQ-020 csr_rdata returns current register contents for matching csr_rnum; unmapped numbers return 32'h0. A write becomes visible on read the cycle after the edge.
REQ-021 Writes to unmapped numbers have no effect.

Reset
REQ-022 On reset, all of the following clear to 0 on the next edge, overriding any same-cycle write:
- TCFG, TVAL and pending of every channel;
- stable counter;
- timer_irq, irq_any, csr_rdata-visible state.
REQ-023 Reset asserted mid-countdown aborts counting; no interrupt is raised after reset deasserts until a new TCFG write with En=1.

Structure
REQ-024 TCFG_BASE (14'h41), TVAL_BASE (14'h42), TICLR_BASE (14'h44) and the TCFG bit-position constants shall live in cpuDefine.
REQ-025 One sub-module, csr_timer_chan, holds one channel's TCFG/TVAL/pending. It shall be instantiated NUM_TIMERS times via generate; read muxing and the stable counter stay in the top.

Verification
REQ-026 Scenario: TCFG0 write 0x0000_0013 (En, Periodic, InitVal=4) -> TVAL0=16 next cycle; timer_irq[0] rises 16 cycles later; TVAL0 reloads 16.
REQ-027 Scenario: TCFG1 write 0x0000_0009 (one-shot, InitVal=2) -> timer_irq[1] after 8 cycles; TVAL1 stays 0 for ≥20 cycles; no second irq after TICLR1 clear.
REQ-028 Scenario: TICLR0 write 0x1 in the exact expiry cycle -> timer_irq[0] stays 1; a second TICLR0 write clears it next cycle.
REQ-029 Scenario: masked write csr_me=1, wmask=0x1, wdata=0x0 to a TCFG0 holding 0x13 -> TCFG0 reads 0x12; TVAL frozen.
REQ-030 Scenario: reset asserted 3 cycles into a countdown -> all outputs 0 next cycle; no irq for 100 cycles after release.
REQ-031 Scenario: NUM_TIMERS=4, TIMER_WIDTH=8; write TVAL and an unmapped CSR -> no state change; read of unmapped returns 0; counter_lo increments 1 per cycle.

Source files
------------

// File: rtl/cpuDefine.sv
// Shared CSR numbering, TCFG field positions and small CSR helpers for the timer bank.
package cpuDefine;

  localparam logic [13:0] TCFG_BASE  = 14'h41;
  localparam logic [13:0] TVAL_BASE  = 14'h42;
  localparam logic [13:0] TICLR_BASE = 14'h44;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

  typedef enum logic [1:0] {
    CSR_NONE,
    CSR_TCFG,
    CSR_TVAL,
    CSR_TICLR
  } timer_csr_e;

  function automatic logic [13:0] chan_csr(input logic [13:0] base, input int chan,
                                           input logic [13:0] stride);
    return base + 14'(chan) * stride;
  endfunction

  function automatic timer_csr_e timer_csr_decode(input logic [13:0] num, input int chan,
                                                  input logic [13:0] stride);
    if (num == chan_csr(TCFG_BASE, chan, stride))  return CSR_TCFG;
    if (num == chan_csr(TVAL_BASE, chan, stride))  return CSR_TVAL;
    if (num == chan_csr(TICLR_BASE, chan, stride)) return CSR_TICLR;
    return CSR_NONE;
  endfunction

  // csrxchg semantics: only masked bits take the new data.
  function automatic logic [31:0] csr_merge(input logic [31:0] wdata, input logic [31:0] old,
                                            input logic me, input logic [31:0] wmask);
    logic [31:0] m;
    m = me ? wmask : 32'hFFFF_FFFF;
    return (wdata & m) | (old & ~m);
  endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One timer channel: TCFG, down-counting TVAL and the pending interrupt flag.
module csr_timer_chan
  import cpuDefine::*;
#(
  parameter int          CHAN        = 0,
  parameter int          TIMER_WIDTH = 32,
  parameter logic [13:0] CSR_STRIDE  = 14'h8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_we,
  input  logic                   csr_me,
  input  logic [13:0]            csr_wnum,
  input  logic [31:0]            csr_wdata,
  input  logic [31:0]            csr_wmask,
  output logic [TIMER_WIDTH-1:0] tcfg,
  output logic [TIMER_WIDTH-1:0] tval,
  output logic                   pending
);

  timer_csr_e             wsel;
  logic [31:0]            tcfg_merged;
  logic                   unused_merged;
  logic [TIMER_WIDTH-1:0] tcfg_reg, tcfg_next;
  logic [TIMER_WIDTH-1:0] tval_reg, tval_next;
  logic [TIMER_WIDTH-1:0] reload_val;
  logic                   pending_reg, pending_next;
  logic                   counting, expire, ticlr_clr;

  assign wsel          = csr_we ? timer_csr_decode(csr_wnum, CHAN, CSR_STRIDE) : CSR_NONE;
  assign tcfg_merged   = csr_merge(csr_wdata, 32'(tcfg_reg), csr_me, csr_wmask);
  assign unused_merged = ^tcfg_merged;
  // TICLR always reads as zero, so only the new data bit can request a clear.
  assign ticlr_clr     = (wsel == CSR_TICLR) && csr_wdata[0] && (!csr_me || csr_wmask[0]);
  assign reload_val    = {tcfg_reg[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00};
  assign counting      = tcfg_reg[TCFG_EN] && (tval_reg != '0);
  assign expire        = counting && (tval_reg == TIMER_WIDTH'(1));

  always_comb begin
    tcfg_next    = tcfg_reg;
    tval_next    = tval_reg;
    pending_next = pending_reg;
    // A config write reloads TVAL even if this cycle also expires.
    if (wsel == CSR_TCFG) begin
      tcfg_next = tcfg_merged[TIMER_WIDTH-1:0];
      tval_next = {tcfg_merged[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00};
    end else if (counting) begin
      if (expire) tval_next = tcfg_reg[TCFG_PERIODIC] ? reload_val : '0;
      else        tval_next = tval_reg - TIMER_WIDTH'(1);
    end
    if (expire)         pending_next = 1'b1;
    else if (ticlr_clr) pending_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_reg    <= '0;
      tval_reg    <= '0;
      pending_reg <= 1'b0;
    end else begin
      tcfg_reg    <= tcfg_next;
      tval_reg    <= tval_next;
      pending_reg <= pending_next;
    end
  end

  assign tcfg    = tcfg_reg;
  assign tval    = tval_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of CSR-mapped countdown timers plus a free-running stable counter.
module csr_timer_bank
  import cpuDefine::*;
#(
  parameter int          NUM_TIMERS  = 2,
  parameter int          TIMER_WIDTH = 32,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [13:0] CSR_STRIDE  = 14'h8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_we,
  input  logic                  csr_me,
  input  logic [13:0]           csr_wnum,
  input  logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_wmask,
  input  logic [13:0]           csr_rnum,
  output logic [31:0]           csr_rdata,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  irq_any,
  output logic [31:0]           counter_hi,
  output logic [31:0]           counter_lo
);

  logic [TIMER_WIDTH-1:0] chan_tcfg [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] chan_tval [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]  pending;
  logic [CNT_WIDTH-1:0]   counter_reg;
  timer_csr_e             rsel;

  generate
    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
      csr_timer_chan #(
        .CHAN        (gi),
        .TIMER_WIDTH (TIMER_WIDTH),
        .CSR_STRIDE  (CSR_STRIDE)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .csr_we    (csr_we),
        .csr_me    (csr_me),
        .csr_wnum  (csr_wnum),
        .csr_wdata (csr_wdata),
        .csr_wmask (csr_wmask),
        .tcfg      (chan_tcfg[gi]),
        .tval      (chan_tval[gi]),
        .pending   (pending[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) counter_reg <= '0;
    else       counter_reg <= counter_reg + CNT_WIDTH'(1);
  end

  // TICLR and unmapped numbers fall through to zero.
  always_comb begin
    csr_rdata = '0;
    rsel      = CSR_NONE;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      rsel = timer_csr_decode(csr_rnum, i, CSR_STRIDE);
      if (rsel == CSR_TCFG) csr_rdata = 32'(chan_tcfg[i]);
      if (rsel == CSR_TVAL) csr_rdata = 32'(chan_tval[i]);
    end
  end

  assign timer_irq  = pending;
  assign irq_any    = |pending;
  assign counter_lo = counter_reg[31:0];
  assign counter_hi = 32'(counter_reg >> 32);

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed scenarios plus random CSR traffic checked against a rule-level timer model.
module tb_csr_timer_bank;

  localparam int          NT     = 4;
  localparam int          TW     = 8;
  localparam int          CW     = 64;
  localparam logic [13:0] STRIDE = 14'h8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          csr_we = 1'b0;
  logic          csr_me = 1'b0;
  logic [13:0]   csr_wnum = '0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_wmask = '0;
  logic [13:0]   csr_rnum = '0;
  logic [31:0]   csr_rdata;
  logic [NT-1:0] timer_irq;
  logic          irq_any;
  logic [31:0]   counter_hi;
  logic [31:0]   counter_lo;

  int tests = 0;
  int fails = 0;

  int unsigned     m_tcfg [NT];
  int unsigned     m_tval [NT];
  bit              m_pend [NT];
  longint unsigned m_cnt;

  always #50 clk = ~clk;

  csr_timer_bank #(
    .NUM_TIMERS  (NT),
    .TIMER_WIDTH (TW),
    .CNT_WIDTH   (CW),
    .CSR_STRIDE  (STRIDE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_me     (csr_me),
    .csr_wnum   (csr_wnum),
    .csr_wdata  (csr_wdata),
    .csr_wmask  (csr_wmask),
    .csr_rnum   (csr_rnum),
    .csr_rdata  (csr_rdata),
    .timer_irq  (timer_irq),
    .irq_any    (irq_any),
    .counter_hi (counter_hi),
    .counter_lo (counter_lo)
  );

  task automatic chk(input string tag, input int idx, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // Model of one clock edge, written directly from the timer rules.
  task automatic model_edge(input bit rst, input bit we, input bit me, input int unsigned wnum,
                            input int unsigned wdata, input int unsigned wmask);
    int unsigned m, wv, cmask;
    bit fires, cfg_hit, clr_hit, en;
    cmask = 32'hFFFF_FFFF >> (32 - TW);
    m = me ? wmask : 32'hFFFF_FFFF;
    for (int i = 0; i < NT; i++) begin
      if (rst) begin
        m_tcfg[i] = 0; m_tval[i] = 0; m_pend[i] = 0;
      end else begin
        en      = (m_tcfg[i] & 1) != 0;
        cfg_hit = we && (wnum == 32'h41 + i * 8);
        clr_hit = we && (wnum == 32'h44 + i * 8) && ((wdata & m & 1) != 0);
        fires   = en && (m_tval[i] == 1);
        if (cfg_hit) begin
          wv = ((wdata & m) | (m_tcfg[i] & ~m)) & cmask;
          m_tcfg[i] = wv;
          m_tval[i] = wv & ~32'd3;
        end else if (en && m_tval[i] != 0) begin
          if (fires) m_tval[i] = ((m_tcfg[i] & 2) != 0) ? (m_tcfg[i] & ~32'd3) : 0;
          else       m_tval[i] = m_tval[i] - 1;
        end
        if (fires)        m_pend[i] = 1;
        else if (clr_hit) m_pend[i] = 0;
      end
    end
    m_cnt = rst ? 64'd0 : m_cnt + 1;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    csr_rnum = num;
    #1;
    v = csr_rdata;
  endtask

  task automatic check_all();
    logic [31:0]   v;
    logic [NT-1:0] ev;
    bit            any;
    any = 0;
    for (int i = 0; i < NT; i++) begin
      rd(14'(32'h41 + i * 8), v); chk("tcfg", i, 64'(v), 64'(m_tcfg[i]));
      rd(14'(32'h42 + i * 8), v); chk("tval", i, 64'(v), 64'(m_tval[i]));
      ev[i] = m_pend[i];
      any   = any | m_pend[i];
    end
    rd(14'h44, v);   chk("ticlr_rd", 0, 64'(v), 64'd0);
    rd(14'h3FFF, v); chk("unmapped_rd", 0, 64'(v), 64'd0);
    chk("timer_irq", 0, 64'(timer_irq), 64'(ev));
    chk("irq_any", 0, 64'(irq_any), 64'(any));
    chk("counter_lo", 0, 64'(counter_lo), 64'(m_cnt[31:0]));
    chk("counter_hi", 0, 64'(counter_hi), 64'(m_cnt[63:32]));
  endtask

  task automatic step(input bit rst, input bit we, input bit me, input logic [13:0] wnum,
                      input logic [31:0] wdata, input logic [31:0] wmask);
    reset = rst; csr_we = we; csr_me = me;
    csr_wnum = wnum; csr_wdata = wdata; csr_wmask = wmask;
    model_edge(rst, we, me, 32'(wnum), wdata, wmask);
    @(posedge clk);
    #1;
    reset = 1'b0; csr_we = 1'b0; csr_me = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 14'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] data);
    step(0, 1, 0, num, data, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] prev_lo;
    int unsigned bsel, chan;
    logic [13:0] rnum_w;

    // Reset state
    step(1, 0, 0, 14'h0, 32'h0, 32'h0);
    step(1, 1, 0, 14'h41, 32'h13, 32'h0);
    chk("rst_irq", 0, 64'(timer_irq), 64'd0);
    chk("rst_cnt", 0, 64'(counter_lo), 64'd0);

    // Periodic channel 0, InitVal=4
    wr(14'h41, 32'h13);
    rd(14'h42, v); chk("s026_tval_load", 0, 64'(v), 64'd16);
    idle(15);
    rd(14'h42, v); chk("s026_tval_last", 0, 64'(v), 64'd1);
    chk("s026_no_irq_yet", 0, 64'(timer_irq[0]), 64'd0);
    idle(1);
    chk("s026_irq", 0, 64'(timer_irq[0]), 64'd1);
    rd(14'h42, v); chk("s026_reload", 0, 64'(v), 64'd16);

    // Clear coinciding with expiry: expiry wins
    wr(14'h44, 32'h1);
    chk("s028_cleared", 0, 64'(timer_irq[0]), 64'd0);
    idle(14);
    rd(14'h42, v); chk("s028_tval_one", 0, 64'(v), 64'd1);
    wr(14'h44, 32'h1);
    chk("s028_expiry_wins", 0, 64'(timer_irq[0]), 64'd1);
    wr(14'h44, 32'h1);
    chk("s028_second_clear", 0, 64'(timer_irq[0]), 64'd0);

    // Masked write clears En only
    step(0, 1, 1, 14'h41, 32'h0, 32'h1);
    rd(14'h41, v); chk("s029_tcfg", 0, 64'(v), 64'h12);
    idle(5);
    rd(14'h42, v); chk("s029_frozen", 0, 64'(v), 64'd16);

    // One-shot channel 1, InitVal=2
    wr(14'h49, 32'h9);
    rd(14'h4A, v); chk("s027_tval_load", 1, 64'(v), 64'd8);
    idle(8);
    chk("s027_irq", 1, 64'(timer_irq[1]), 64'd1);
    idle(20);
    rd(14'h4A, v); chk("s027_halted", 1, 64'(v), 64'd0);
    wr(14'h4C, 32'h1);
    idle(20);
    chk("s027_no_second", 1, 64'(timer_irq[1]), 64'd0);

    // Periodic with InitVal=0 never counts
    wr(14'h51, 32'h3);
    idle(5);
    rd(14'h52, v); chk("init0_tval", 2, 64'(v), 64'd0);

    // TVAL and unmapped writes ignored; bits above TIMER_WIDTH read 0
    wr(14'h42, 32'h55);
    rd(14'h42, v); chk("s031_tval_ro", 0, 64'(v), 64'd16);
    wr(14'h61, 32'h13);
    wr(14'h100, 32'hFFFF_FFFF);
    rd(14'h61, v); chk("s031_unmapped", 0, 64'(v), 64'd0);
    wr(14'h59, 32'hFFFF_FF05);
    rd(14'h59, v); chk("s031_tcfg_width", 3, 64'(v), 64'h05);
    rd(14'h5A, v); chk("s031_tval3", 3, 64'(v), 64'd4);
    prev_lo = counter_lo;
    idle(1);
    chk("s031_cnt_inc", 0, 64'(counter_lo), 64'(prev_lo + 32'd1));

    // Random CSR traffic
    for (int n = 0; n < 300; n++) begin
      bsel = $urandom % 4;
      chan = $urandom % 5;
      case (bsel)
        0:       rnum_w = 14'(32'h41 + chan * 8);
        1:       rnum_w = 14'(32'h42 + chan * 8);
        2:       rnum_w = 14'(32'h44 + chan * 8);
        default: rnum_w = 14'($urandom_range(0, 16383));
      endcase
      step(($urandom % 60) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0, rnum_w,
           (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 63), $urandom);
    end

    // Reset mid-countdown, overriding a same-cycle write
    wr(14'h41, 32'h13);
    idle(3);
    step(1, 1, 0, 14'h49, 32'h13, 32'h0);
    chk("s030_irq", 0, 64'(timer_irq), 64'd0);
    chk("s030_any", 0, 64'(irq_any), 64'd0);
    chk("s030_hi", 0, 64'(counter_hi), 64'd0);
    chk("s030_lo", 0, 64'(counter_lo), 64'd0);
    rd(14'h49, v); chk("s030_tcfg1", 1, 64'(v), 64'd0);
    for (int k = 0; k < 100; k++) begin
      idle(1);
      chk("s030_quiet", k, 64'(timer_irq), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
